// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - D-side request/response bus between the core and dmem_ctrl
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - multi-cycle 64-bit data-memory controller with fixed array latency
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 128,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [3:0]  CNT_INIT   = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic [3:0]         cnt;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic [63:0]        wdata_q;
  logic [63:0]        rsp_rdata_q;
  logic               rsp_err_q;
  logic [63:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               req_err;
  logic               commit;

  // Full 64-bit range compare so high address bits can never alias into the array.
  assign req_err = (bus.req_addr[2:0] != 3'b000) | (bus.req_addr >= BYTE_LIMIT);
  assign accept  = bus.req_valid & bus.req_ready;
  assign commit  = (state == ACCESS) && (cnt == 4'd0);

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      IDLE: begin
        bus.req_ready = ~rst;
        bus.busy      = 1'b0;
        if (accept) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            idx_q       <= bus.req_addr[IDX_W+2:3];
            wdata_q     <= bus.req_wdata;
            cnt         <= CNT_INIT;
            rsp_err_q   <= req_err;
            rsp_rdata_q <= '0;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             rsp_rdata_q <= we_q ? 64'd0 : mem[idx_q];
        end
        RESP: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Backing array write; gated by rst so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_ctrl_if bus();

  dmem_ctrl #(.DEPTH_WORDS(128), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, want no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        check("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic err, input logic [63:0] rdata, output int acc);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: req_ready=0 after %0d cycles, want 1", n);
      acc = -1;
    end else begin
      acc     = cyc + 1;
      e.rdata = rdata;
      e.err   = err;
      e.cyc   = acc + (err ? 0 : LAT);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int   acc;
    int   acc_a;
    int   acc_b;

    vecs[0]  = '{1'b1, 64'h10,                  64'hDEADBEEF_01234567, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 64'h10,                  64'h0,                 1'b0, 64'hDEADBEEF_01234567};
    vecs[2]  = '{1'b0, 64'h13,                  64'h0,                 1'b1, 64'h0};
    vecs[3]  = '{1'b1, 64'h3F8,                 64'h1111_2222_3333_4444, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 64'h400,                 64'hBAD0_BAD0_BAD0_BAD0, 1'b1, 64'h0};
    vecs[5]  = '{1'b0, 64'h3F8,                 64'h0,                 1'b0, 64'h1111_2222_3333_4444};
    vecs[6]  = '{1'b1, 64'h8000_0000_0000_0010, 64'hFFFF_0000_FFFF_0000, 1'b1, 64'h0};
    vecs[7]  = '{1'b0, 64'h10,                  64'h0,                 1'b0, 64'hDEADBEEF_01234567};
    vecs[8]  = '{1'b1, 64'h0,                   64'hA5A5_5A5A_C3C3_3C3C, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 64'h0,                   64'h0,                 1'b0, 64'hA5A5_5A5A_C3C3_3C3C};
    vecs[10] = '{1'b0, 64'h404,                 64'h0,                 1'b1, 64'h0};
    vecs[11] = '{1'b1, 64'h3FF,                 64'h7777_7777_7777_7777, 1'b1, 64'h0};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // reset held for two cycles
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_rsp_rdata", bus.rsp_rdata,      64'd0);
    check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // table-driven transactions
    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata, acc);
    end
    drain();

    // busy ignore: second request held from the ACCESS cycle, accepted at first IDLE
    do_req(1'b0, 64'h3F8, 64'h0, 1'b0, 64'h1111_2222_3333_4444, acc_a);
    check("busy_during_access", 64'(bus.busy), 64'd1);
    do_req(1'b0, 64'h0, 64'h0, 1'b0, 64'hA5A5_5A5A_C3C3_3C3C, acc_b);
    check("busy_accept_edge", 64'(acc_b), 64'(acc_a + LAT + 2));
    drain();

    // error spacing: error request blocks for two cycles
    do_req(1'b0, 64'h13, 64'h0, 1'b1, 64'h0, acc_a);
    do_req(1'b0, 64'h10, 64'h0, 1'b0, 64'hDEADBEEF_01234567, acc_b);
    check("err_accept_edge", 64'(acc_b), 64'(acc_a + 2));
    drain();

    // reset right before the commit edge of a store
    @(negedge clk);
    check("abort_ready_before", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 64'h10;
    bus.req_wdata = 64'h5555_5555_5555_5555;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",      64'(bus.busy),      64'd0);
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("abort_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_req(1'b0, 64'h10, 64'h0, 1'b0, 64'hDEADBEEF_01234567, acc);
    drain();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
